vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing in the pixel-clock domain driven by the 25.125 MHz PLL global output.
- Produces sync signals, the display-enable window, pixel coordinates and frame/line strobes for the downstream pixel/colour stage.
- A PLL-lock qualifier holds the raster idle until the clock is stable.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 40 ++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate type and sync polarity constants for the
// 640x480@60 raster generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef logic [9:0] coord_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter with synchronous clear, increment enable and a terminal-count flag.
module vga_axis_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Anything at or beyond the last legal value wraps, so a corrupted count self-heals.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q >= LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q >= LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters plus registered decode of sync,
// display enable, active-area coordinates and line/frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit VSYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output logic   hsync_o,
  output logic   vsync_o,
  output logic   de_o,
  output coord_t col_o,
  output coord_t row_o,
  output logic   line_start_o,
  output logic   frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = $clog2(max_int(H_TOTAL, V_TOTAL));

  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_tc;
  // Frame start decodes the origin directly, so the vertical wrap flag has no consumer.
  logic          unused_v_tc;

  vga_axis_counter #(.N(H_TOTAL), .W(CW)) u_h_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~en_i),
    .inc_i (1'b1),
    .cnt_o (h_cnt),
    .tc_o  (h_tc)
  );

  vga_axis_counter #(.N(V_TOTAL), .W(CW)) u_v_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~en_i),
    .inc_i (h_tc),
    .cnt_o (v_cnt),
    .tc_o  (unused_v_tc)
  );

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_q, de_d;
  coord_t col_q, col_d;
  coord_t row_q, row_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;

  always_comb begin
    de_d          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_d       = ((h_cnt >= HS_BEGIN) && (h_cnt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((v_cnt >= VS_BEGIN) && (v_cnt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    col_d         = de_d ? coord_t'(h_cnt) : '0;
    row_d         = de_d ? coord_t'(v_cnt) : '0;
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Losing PLL lock behaves exactly like reset so a frame never resumes mid-raster.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign col_o         = col_q;
  assign row_o         = row_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing instance
// share stimulus and are both compared every cycle against a linear-index raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] col;
    logic [9:0] row;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    logic rst;
    logic en;
    int   n;
    out_t exp;
  } vec_t;

  // Shrunken timing so whole frames fit in a short run.
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int FRAME_S = SHT * SVT;
  localparam int FRAME_D = 800 * 525;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_col, d_row;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_col, s_row;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .hsync_o(d_hs), .vsync_o(d_vs), .de_o(d_de),
    .col_o(d_col), .row_o(d_row),
    .line_start_o(d_ls), .frame_start_o(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_s (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .hsync_o(s_hs), .vsync_o(s_vs), .de_o(s_de),
    .col_o(s_col), .row_o(s_row),
    .line_start_o(s_ls), .frame_start_o(s_fs)
  );

  out_t od, os;
  assign od = {d_hs, d_vs, d_de, d_col, d_row, d_ls, d_fs};
  assign os = {s_hs, s_vs, s_de, s_col, s_row, s_ls, s_fs};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int kd = 0;
  int ks = 0;
  int s_vs_low, s_de_hi, s_ls_cnt, s_fs_cnt;
  int fs_cycles[$];

  function automatic out_t mk(logic hs, logic vs, logic de, int col, int row, logic ls, logic fs);
    out_t o;
    o.hs = hs; o.vs = vs; o.de = de;
    o.col = 10'(col); o.row = 10'(row);
    o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Expected outputs for the k-th enabled cycle of a frame (active-low syncs).
  function automatic out_t ref_out(int k, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs);
    int ht = ha + hf + hs + hb;
    int h = k % ht;
    int v = k / ht;
    out_t o;
    o.de  = (h < ha) && (v < va);
    o.hs  = !((h >= ha + hf) && (h < ha + hf + hs));
    o.vs  = !((v >= va + vf) && (v < va + vf + vs));
    o.col = o.de ? 10'(h) : 10'd0;
    o.row = o.de ? 10'(v) : 10'd0;
    o.ls  = (h == 0);
    o.fs  = (k == 0);
    return o;
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b want hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b",
               name, cyc, act.hs, act.vs, act.de, act.col, act.row, act.ls, act.fs,
               exp.hs, exp.vs, exp.de, exp.col, exp.row, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Advance n clock edges; every edge both instances are compared to the model.
  task automatic step(int n);
    out_t ed, es;
    out_t rst_o;
    rst_o = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (rst || !en) begin
        ed = rst_o; es = rst_o; kd = 0; ks = 0;
      end else begin
        ed = ref_out(kd, 640, 16, 96, 48, 480, 10, 2);
        es = ref_out(ks, SHA, SHF, SHS, SHB, SVA, SVF, SVS);
        kd = (kd + 1) % FRAME_D;
        ks = (ks + 1) % FRAME_S;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("cycle_default", od, ed);
      check("cycle_small", os, es);
      if (!s_vs) s_vs_low++;
      if (s_de) s_de_hi++;
      if (s_ls) s_ls_cnt++;
      if (s_fs) begin
        s_fs_cnt++;
        fs_cycles.push_back(cyc);
      end
    end
  endtask

  vec_t tbl[12];
  out_t rst_v;

  initial begin
    rst_v = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tbl[0]  = '{1'b1, 1'b1, 5,  rst_v};
    tbl[1]  = '{1'b0, 1'b1, 1,  mk(1'b1, 1'b1, 1'b1, 0,   0, 1'b1, 1'b1)};
    tbl[2]  = '{1'b0, 1'b1, 639, mk(1'b1, 1'b1, 1'b1, 639, 0, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b1, 1,  mk(1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b1, 16, mk(1'b0, 1'b1, 1'b0, 0,   0, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 95, mk(1'b0, 1'b1, 1'b0, 0,   0, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b1, 1,  mk(1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 1'b1, 47, mk(1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b1, 1,  mk(1'b1, 1'b1, 1'b1, 0,   1, 1'b1, 1'b0)};
    tbl[9]  = '{1'b0, 1'b0, 1,  rst_v};
    tbl[10] = '{1'b0, 1'b1, 1,  mk(1'b1, 1'b1, 1'b1, 0,   0, 1'b1, 1'b1)};
    tbl[11] = '{1'b1, 1'b0, 1,  rst_v};

    for (int t = 0; t < 12; t++) begin
      rst = tbl[t].rst;
      en  = tbl[t].en;
      step(tbl[t].n);
      check($sformatf("table_%0d", t), od, tbl[t].exp);
    end

    // Two full shrunken frames: per-frame counts and frame-strobe spacing.
    rst = 1'b1; en = 1'b1;
    step(1);
    s_vs_low = 0; s_de_hi = 0; s_ls_cnt = 0; s_fs_cnt = 0;
    fs_cycles.delete();
    rst = 1'b0;
    step(2 * FRAME_S);
    check_int("vsync_low_cycles", s_vs_low, 2 * SVS * SHT);
    check_int("de_high_cycles", s_de_hi, 2 * SHA * SVA);
    check_int("line_strobes", s_ls_cnt, 2 * SVT);
    check_int("frame_strobes", s_fs_cnt, 2);
    if (fs_cycles.size() == 2) check_int("frame_period", fs_cycles[1] - fs_cycles[0], FRAME_S);
    else check_int("frame_period_pulses", fs_cycles.size(), 2);

    // Reset while both syncs are asserted (h=22, v=14).
    step(14 * SHT + 23);
    check_int("mid_hsync_asserted", int'(s_hs), 0);
    check_int("mid_vsync_asserted", int'(s_vs), 0);
    rst = 1'b1;
    step(1);
    check_int("reset_hsync_released", int'(s_hs), 1);
    check_int("reset_vsync_released", int'(s_vs), 1);
    rst = 1'b0;
    step(1);
    check_int("restart_frame_start", int'(s_fs), 1);
    check_int("restart_default_frame_start", int'(d_fs), 1);

    // Short enable drop mid-frame.
    step(100);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(1);
    check_int("reenable_frame_start", int'(s_fs), 1);
    check_int("reenable_row", int'(s_row), 0);

    // Random reset / enable disturbances, checked every cycle by the model.
    for (int i = 0; i < 20000; i++) begin
      int r;
      r = int'($urandom_range(999));
      rst = (r < 2);
      en  = !(r >= 2 && r < 8);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
